// File: rtl/fifo_synch_nrmw.sv
// Synchronous FIFO with multi-word enqueue (up to n_write_p) and multi-word dequeue (up to n_read_p) per cycle.
// Optional protocol-error checking is compiled in with FIFO_SYNCH_NRMW_ERR_CHK_EN.
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
`ifndef N_WRITE
`define N_WRITE 4
`endif

module fifo_synch_nrmw #(
    parameter int width_p     = `BIT_WIDTH,
    parameter int ptr_width_p = 8,
    parameter int n_write_p   = `N_WRITE,
    parameter int n_read_p    = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [n_write_p-1:0][width_p-1:0]      data_i,
    input  logic [$clog2(n_write_p+1)-1:0]         wr_cnt_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic [n_read_p-1:0][width_p-1:0]       data_o,
    output logic [$clog2(n_read_p+1)-1:0]          avail_o,
    output logic                                   valid_o,
    input  logic [$clog2(n_read_p+1)-1:0]          yumi_cnt_i,
    output logic [ptr_width_p:0]                   count_o,
    output logic                                   err_o
);

    localparam int cap_p = 1 << ptr_width_p;
    localparam int pw_p  = ptr_width_p + 1;
    localparam int wcw_p = $clog2(n_write_p + 1);
    localparam int rcw_p = $clog2(n_read_p + 1);

    logic [pw_p-1:0]    wr_ptr_r;
    logic [pw_p-1:0]    rd_ptr_r;
    logic [width_p-1:0] mem_r [cap_p];
    logic [pw_p-1:0]    count_s;
    logic [pw_p-1:0]    space_s;
    logic [rcw_p-1:0]   avail_s;
    logic               wr_cnt_ok_s;
    logic               enq_s;
    logic               deq_s;

    assign count_s     = wr_ptr_r - rd_ptr_r;
    assign space_s     = pw_p'(cap_p) - count_s;
    assign wr_cnt_ok_s = (wr_cnt_i <= wcw_p'(n_write_p));
    // Space is judged from registered pointers only; a same-cycle dequeue does not free room.
    assign ready_o     = (space_s >= pw_p'(n_write_p));
    assign enq_s       = valid_i & ready_o & (wr_cnt_i != wcw_p'(0)) & wr_cnt_ok_s;
    assign deq_s       = (yumi_cnt_i != rcw_p'(0)) & (yumi_cnt_i <= avail_s);

    assign count_o = count_s;
    assign valid_o = (count_s != pw_p'(0));
    assign avail_o = avail_s;

    // Words presentable at the head: occupancy clamped to the read width.
    always_comb begin
        avail_s = rcw_p'(n_read_p);
        if (count_s < pw_p'(n_read_p)) begin
            avail_s = rcw_p'(count_s);
        end else begin
            avail_s = rcw_p'(n_read_p);
        end
    end

    // Head window read straight from storage; index arithmetic wraps modulo cap_p.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < n_read_p; i++) begin
            data_o[i] = mem_r[rd_ptr_r[ptr_width_p-1:0] + ptr_width_p'(i)];
        end
    end

    // Storage write: lanes below wr_cnt_i land at consecutive (wrapping) indices; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < n_write_p; i++) begin
            if (enq_s && (wcw_p'(i) < wr_cnt_i)) begin
                mem_r[wr_ptr_r[ptr_width_p-1:0] + ptr_width_p'(i)] <= data_i[i];
            end
        end
    end

    // Pointer update; the wrap bit distinguishes full from empty.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= pw_p'(0);
            rd_ptr_r <= pw_p'(0);
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + pw_p'(wr_cnt_i);
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + pw_p'(yumi_cnt_i);
            end
        end
    end

`ifdef FIFO_SYNCH_NRMW_ERR_CHK_EN
    logic err_r;

    // Sticky protocol-error flag: over-read, push while not ready, or oversized write count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
        end else if ((yumi_cnt_i > avail_s) || (valid_i && !ready_o) || !wr_cnt_ok_s) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: doc/fifo_synch_nrmw.md
FIFO_SYNCH_NRMW -- requirements
Module: fifo_synch_nrmw

Interface
REQ-001 SHALL have parameter width_p, default `BIT_WIDTH: bits per word.
REQ-002 SHALL have parameter ptr_width_p, default 8: depth cap_p = 2^ptr_width_p words.
REQ-003 SHALL have parameter n_write_p, default `N_WRITE: maximum words enqueued per cycle, 1..cap_p.
REQ-004 SHALL have parameter n_read_p, default 2: maximum words dequeued per cycle, 1..cap_p.
REQ-005 SHALL have port clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n_i  in  1  asynchronous active-low reset.
REQ-007 SHALL have port data_i  in  n_write_p x width_p  enqueue words; lane 0 is the oldest.
REQ-008 SHALL have port wr_cnt_i  in  $clog2(n_write_p+1)  number of valid lanes, from lane 0 upward.
REQ-009 SHALL have port valid_i  in  1  enqueue request.
REQ-010 SHALL have port ready_o  out  1  space for n_write_p words.
REQ-011 SHALL have port data_o  out  n_read_p x width_p  head words; lane i = entry head+i.
REQ-012 SHALL have port avail_o  out  $clog2(n_read_p+1)  min(occupancy, n_read_p).
REQ-013 SHALL have port valid_o  out  1  occupancy > 0.
REQ-014 SHALL have port yumi_cnt_i  in  $clog2(n_read_p+1)  words consumed this cycle; 0 = none.
REQ-015 SHALL have port count_o  out  ptr_width_p+1  current occupancy, 0..cap_p.
REQ-016 SHALL have port err_o  out  1  sticky protocol-error flag.

Function
REQ-017 SHALL keep read/write pointers ptr_width_p+1 bits wide; the MSB is the wrap bit; storage is indexed by the low ptr_width_p bits, modulo cap_p.
REQ-018 SHALL derive count_o = write_ptr - read_ptr (ptr_width_p+1-bit subtraction); empty when count_o == 0, full when count_o == cap_p.
REQ-019 SHALL drive ready_o = (cap_p - count_o >= n_write_p), from registered state only; a same-cycle dequeue SHALL NOT count as extra space.
REQ-020 SHALL enqueue when valid_i & ready_o & wr_cnt_i != 0: lanes 0..wr_cnt_i-1 go to write_ptr+0..wr_cnt_i-1 (mod cap_p), and write_ptr advances by wr_cnt_i.
REQ-021 SHALL ignore valid_i when ready_o = 0; no state change results.
REQ-022 SHALL dequeue when yumi_cnt_i != 0 and yumi_cnt_i <= avail_o: read_ptr advances by yumi_cnt_i.
REQ-023 SHALL ignore a dequeue with yumi_cnt_i > avail_o; read_ptr is unchanged.
REQ-024 SHALL drive data_o lane i from storage[read_ptr+i]; lanes i >= avail_o are don't-care.
REQ-025 SHALL make enqueued words visible on data_o the cycle after the enqueue edge; there is no same-cycle input-to-output bypass.
REQ-026 SHALL apply a simultaneous enqueue and dequeue in the same edge: count_next = count + wr_cnt - yumi_cnt.
REQ-027 SHALL wrap storage writes that cross index cap_p-1 to index 0 within a single cycle.

Reset
REQ-028 SHALL, while reset_n_i = 0, immediately force read_ptr = write_ptr = 0 and err_o = 0, giving count_o = 0, valid_o = 0, avail_o = 0 and ready_o = 1.
REQ-029 SHALL NOT reset storage contents; in-flight requests during reset are discarded.

Configuration
REQ-030 SHALL compile in protocol-error checking when macro FIFO_SYNCH_NRMW_ERR_CHK_EN is defined: err_o sets on yumi_cnt_i > avail_o, on valid_i & ~ready_o, or on wr_cnt_i > n_write_p, and holds until reset.
REQ-031 SHALL tie err_o to 0 when the macro is undefined; the port still exists and all other behaviour is identical.

Verification (width_p=16, ptr_width_p=3, n_write_p=4, n_read_p=2)
REQ-032 SHALL cover: reset, then enqueue 0xA0..0xA3 with wr_cnt 4 -> next cycle count_o=4, data_o={0xA0,0xA1}, avail_o=2, ready_o=1.
REQ-033 SHALL cover: two 4-word enqueues -> count_o=8, ready_o=0; a third valid_i is ignored and count_o stays 8.
REQ-034 SHALL cover: count 4, enqueue 4 with yumi_cnt 2 in the same cycle -> count_o=6, data_o[0] = third word written.
REQ-035 SHALL cover: wrap case, write_ptr=6, enqueue 0xB0..0xB3 -> the words occupy indices 6,7,0,1 and are read out in order.
REQ-036 SHALL cover: count 1, yumi_cnt 2 -> pointers unchanged; err_o=1 with FIFO_SYNCH_NRMW_ERR_CHK_EN, err_o=0 without it.
REQ-037 SHALL cover: reset_n_i asserted mid-stream at count 5 -> count_o=0 and valid_o=0 with no clock edge, and ready_o=1.
